// File: rtl/rl_ram_pkg.sv
// Shared types and helpers for the 1R1W RAM slice.
// Holds the read-during-write mode and lane-count helper.
package rl_ram_pkg;

    typedef enum logic {
        RDW_NEW = 1'b0,
        RDW_OLD = 1'b1
    } rdw_e;

    function automatic int nbe_f(input int dbits, input int bew);
        if (bew < 1) begin
            return 1;
        end
        return (dbits + bew - 1) / bew;
    endfunction

endpackage

// File: rtl/rl_ram_1r1w_array.sv
// Raw storage for the 1R1W RAM.
// Lane-masked write, synchronous read with an unregistered address.
module rl_ram_1r1w_array
    import rl_ram_pkg::*;
#(
    parameter int ABITS = 10,
    parameter int DBITS = 32,
    parameter int BEW   = 8,
    parameter int NBE   = nbe_f(DBITS, BEW)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [ABITS-1:0] waddr_i,
    input  logic [DBITS-1:0] din_i,
    input  logic [NBE-1:0]   be_i,
    input  logic             re_i,
    input  logic [ABITS-1:0] raddr_i,
    output logic [DBITS-1:0] rdata_o
);

    localparam int DEPTH = 1 << ABITS;

    logic [DBITS-1:0] mem [0:DEPTH-1];
    logic [DBITS-1:0] wmask;
    logic [DBITS-1:0] rdata_q;

    for (genvar b = 0; b < DBITS; b++) begin : g_mask
        assign wmask[b] = be_i[b / BEW];
    end

    // Lane-masked write; the array itself is never cleared.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= (mem[waddr_i] & ~wmask)
                          | (din_i & wmask);
        end
    end

    // Synchronous read; returns pre-write contents on a collision.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/rl_ram_1r1w_rdw.sv
// 1R1W RAM with byte enables and selectable read-during-write.
// Adds lane forwarding, optional output register and valid tracking.
module rl_ram_1r1w_rdw
    import rl_ram_pkg::*;
#(
    parameter int   ABITS   = 10,
    parameter int   DBITS   = 32,
    parameter int   BEW     = 8,
    parameter rdw_e RDW     = RDW_NEW,
    parameter int   REG_OUT = 0,
    localparam int  NBE     = nbe_f(DBITS, BEW)
) (
    input  logic             rst_ni,
    input  logic             clk_i,
    input  logic [ABITS-1:0] waddr_i,
    input  logic [DBITS-1:0] din_i,
    input  logic             we_i,
    input  logic [NBE-1:0]   be_i,
    input  logic [ABITS-1:0] raddr_i,
    input  logic             re_i,
    output logic [DBITS-1:0] dout_o,
    output logic             dout_valid_o
);

    if (ABITS < 1 || DBITS < 1 || BEW < 1 || BEW > DBITS ||
        (REG_OUT != 0 && REG_OUT != 1)) begin : g_bad_param
        $error("rl_ram_1r1w_rdw: illegal parameter set");
    end

    logic             wr_en;
    logic             hit;
    logic [DBITS-1:0] wmask;
    logic [DBITS-1:0] arr_q;
    logic [DBITS-1:0] fmask_q;
    logic [DBITS-1:0] fdata_q;
    logic             v1_q;
    logic [DBITS-1:0] rd_data;

    assign wr_en = we_i & rst_ni;
    assign hit   = (RDW == RDW_NEW) && wr_en && re_i
                && (waddr_i == raddr_i);

    for (genvar b = 0; b < DBITS; b++) begin : g_mask
        assign wmask[b] = be_i[b / BEW];
    end

    rl_ram_1r1w_array #(
        .ABITS (ABITS),
        .DBITS (DBITS),
        .BEW   (BEW),
        .NBE   (NBE)
    ) u_array (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (wr_en),
        .waddr_i (waddr_i),
        .din_i   (din_i),
        .be_i    (be_i),
        .re_i    (re_i),
        .raddr_i (raddr_i),
        .rdata_o (arr_q)
    );

    // Capture forwarded lanes alongside the array read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fmask_q <= '0;
            fdata_q <= '0;
            v1_q    <= 1'b0;
        end else begin
            v1_q <= re_i;
            if (re_i) begin
                fmask_q <= hit ? wmask : '0;
                fdata_q <= din_i & wmask;
            end
        end
    end

    assign rd_data = (arr_q & ~fmask_q) | (fdata_q & fmask_q);

    if (REG_OUT == 1) begin : g_reg
        logic [DBITS-1:0] dout_q;
        logic             v2_q;

        // Second stage: load only when a read completes.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                dout_q <= '0;
                v2_q   <= 1'b0;
            end else begin
                v2_q <= v1_q;
                if (v1_q) begin
                    dout_q <= rd_data;
                end
            end
        end

        assign dout_o       = dout_q;
        assign dout_valid_o = v2_q;
    end else begin : g_noreg
        assign dout_o       = rd_data;
        assign dout_valid_o = v1_q;
    end

endmodule

// File: tb/tb_rl_ram_1r1w_rdw.sv
// Scoreboard bench for rl_ram_1r1w_rdw across RDW/REG_OUT/width configs.
// Each config has its own model, queue and monitor.
module tb_rl_ram_1r1w_rdw;
    import rl_ram_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic        re;
    logic [3:0]  waddr;
    logic [3:0]  raddr;
    logic [3:0]  be;
    logic [31:0] din;

    int nvec  = 0;
    int nfail = 0;
    int tnow  = 0;

    event ev_edge;
    event ev_flush;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : cfg
        localparam int   DW = (g == 4) ? 20 : 32;
        localparam int   NB = (DW + 7) / 8;
        localparam rdw_e MD = (g % 2 == 1) ? RDW_OLD : RDW_NEW;
        localparam int   RO = (g == 2 || g == 3) ? 1 : 0;

        logic [DW-1:0] dout;
        logic          dv;
        logic [DW-1:0] mem [16];
        logic [DW-1:0] qd [$];
        int            qt [$];
        logic [DW-1:0] last = '0;

        rl_ram_1r1w_rdw #(
            .ABITS   (4),
            .DBITS   (DW),
            .BEW     (8),
            .RDW     (MD),
            .REG_OUT (RO)
        ) dut (
            .rst_ni       (rst_n),
            .clk_i        (clk),
            .waddr_i      (waddr),
            .din_i        (din[DW-1:0]),
            .we_i         (we),
            .be_i         (be[NB-1:0]),
            .raddr_i      (raddr),
            .re_i         (re),
            .dout_o       (dout),
            .dout_valid_o (dv)
        );

        // Reference model: runs at every sampled edge.
        always @(ev_edge) begin
            logic [DW-1:0] m;
            logic [DW-1:0] rv;
            if (rst_n) begin
                for (int b = 0; b < DW; b++) m[b] = be[b/8];
                if (re) begin
                    rv = mem[raddr];
                    if (MD == RDW_NEW && we && waddr == raddr)
                        rv = (rv & ~m) | (din[DW-1:0] & m);
                    qd.push_back(rv);
                    qt.push_back(tnow + RO);
                end
                if (we) mem[waddr] = (mem[waddr] & ~m) | (din[DW-1:0] & m);
            end
        end

        // Reset discards everything in flight.
        always @(ev_flush) begin
            qd.delete();
            qt.delete();
        end

        // Monitor: compare on the falling edge.
        always @(negedge clk) begin
            logic [DW-1:0] ed;
            int            et;
            nvec++;
            if (!rst_n) begin
                last = '0;
                if (dout !== '0 || dv !== 1'b0) begin
                    nfail++;
                    $display("FAIL cfg%0d reset: dout=%h dv=%b want 0/0",
                             g, dout, dv);
                end
            end else if (dv === 1'b1) begin
                if (qd.size() == 0) begin
                    nfail++;
                    $display("FAIL cfg%0d spurious valid t=%0d dout=%h",
                             g, tnow, dout);
                end else begin
                    ed = qd.pop_front();
                    et = qt.pop_front();
                    last = ed;
                    if (dout !== ed || et != tnow) begin
                        nfail++;
                        $display("FAIL cfg%0d read: got %h@%0d want %h@%0d",
                                 g, dout, tnow, ed, et);
                    end
                end
            end else begin
                if (qt.size() > 0 && qt[0] <= tnow) begin
                    nfail++;
                    $display("FAIL cfg%0d missing valid t=%0d want %h",
                             g, tnow, qd[0]);
                    ed = qd.pop_front();
                    et = qt.pop_front();
                end else if (dv !== 1'b0 || dout !== last) begin
                    nfail++;
                    $display("FAIL cfg%0d hold: dout=%h dv=%b want %h/0",
                             g, dout, dv, last);
                end
            end
        end
    end

    task automatic cyc(input logic w, input logic [3:0] wa,
                       input logic [31:0] d, input logic [3:0] b,
                       input logic r, input logic [3:0] ra);
        we    = w;
        waddr = wa;
        din   = d;
        be    = b;
        re    = r;
        raddr = ra;
        @(posedge clk);
        tnow++;
        ->ev_edge;
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
    endtask

    task automatic hchk(input string nm, input logic [31:0] got,
                        input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic qchk(input string nm, input int sz);
        nvec++;
        if (sz != 0) begin
            nfail++;
            $display("FAIL %s: %0d reads pending, want 0", nm, sz);
        end
    endtask

    initial begin
        logic [31:0] iv;
        logic [3:0]  wa;
        rst_n = 1'b0;
        we    = 1'b0;
        re    = 1'b0;
        waddr = '0;
        raddr = '0;
        be    = '0;
        din   = '0;
        repeat (3) idle();
        rst_n = 1'b1;

        for (int a = 0; a < 16; a++) begin
            iv = 32'h0101_0101 * a;
            if (a == 5)  iv = 32'h1122_3344;
            if (a == 15) iv = 32'h0;
            cyc(1'b1, 4'(a), iv, 4'hF, 1'b0, 4'd0);
        end

        cyc(1'b1, 4'd3, 32'hDEAD_BEEF, 4'hF, 1'b0, 4'd0);
        cyc(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd3);
        #5;
        hchk("wr_rd_r0_data", cfg[0].dout, 32'hDEAD_BEEF);
        hchk("wr_rd_r0_valid", 32'(cfg[0].dv), 32'd1);
        hchk("wr_rd_r1_early", 32'(cfg[2].dv), 32'd0);
        idle();
        #5;
        hchk("wr_rd_r1_data", cfg[2].dout, 32'hDEAD_BEEF);
        hchk("wr_rd_r1_valid", 32'(cfg[2].dv), 32'd1);

        cyc(1'b1, 4'd5, 32'hAABB_CCDD, 4'h5, 1'b1, 4'd5);
        #5;
        hchk("rdw_new", cfg[0].dout, 32'h11BB_33DD);
        hchk("rdw_old", cfg[1].dout, 32'h1122_3344);
        cyc(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd5);
        #5;
        hchk("rdw_old_next", cfg[1].dout, 32'h11BB_33DD);
        hchk("rdw_new_r1", cfg[2].dout, 32'h11BB_33DD);
        idle();

        cyc(1'b1, 4'd15, 32'h000F_FFFF, 4'h4, 1'b0, 4'd0);
        cyc(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd15);
        #5;
        hchk("top_lane_d20", 32'(cfg[4].dout), 32'h000F_0000);
        hchk("top_lane_d32", cfg[0].dout, 32'h000F_0000);

        cyc(1'b1, 4'd7, 32'hFFFF_FFFF, 4'h0, 1'b1, 4'd7);
        #5;
        hchk("be0_new", cfg[0].dout, 32'h0707_0707);
        idle();
        idle();

        for (int a = 0; a < 16; a++)
            cyc(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'(a));
        repeat (3) idle();

        cyc(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd3);
        rst_n = 1'b0;
        ->ev_flush;
        cyc(1'b1, 4'd3, 32'h1234_5678, 4'hF, 1'b0, 4'd0);
        #5;
        hchk("rst_dout_r1", cfg[2].dout, 32'd0);
        hchk("rst_dv_r1", 32'(cfg[2].dv), 32'd0);
        idle();
        rst_n = 1'b1;
        cyc(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd3);
        #5;
        hchk("post_rst_rd", cfg[0].dout, 32'hDEAD_BEEF);
        repeat (3) idle();

        for (int i = 0; i < 3000; i++) begin
            wa = 4'($urandom_range(15));
            cyc(1'($urandom_range(1)), wa, $urandom(),
                4'($urandom_range(15)), 1'($urandom_range(1)),
                ($urandom_range(3) == 0) ? wa : 4'($urandom_range(15)));
        end
        repeat (4) idle();

        qchk("drain_cfg0", cfg[0].qd.size());
        qchk("drain_cfg1", cfg[1].qd.size());
        qchk("drain_cfg2", cfg[2].qd.size());
        qchk("drain_cfg3", cfg[3].qd.size());
        qchk("drain_cfg4", cfg[4].qd.size());

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
